// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all domain resets, filters PLL lock, then releases domains in index order
// with per-domain ready gating, release gap, ready timeout and automatic retry.
module reset_sequencer #(
   parameter int NUM_DOMAINS   = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int MIN_ASSERT    = 32,
   parameter int LOCK_FILTER   = 16,
   parameter int RELEASE_GAP   = 8,
   parameter int READY_TIMEOUT = 4096
) (
   input  logic                   pll_clk,
   input  logic                   sync_rst,
   input  logic                   pll_lock,
   input  logic                   soft_rst_req,
   input  logic [NUM_DOMAINS-1:0] domain_ready,
   output logic [NUM_DOMAINS-1:0] rst_out,
   output logic [NUM_DOMAINS-1:0] rst_out_n,
   output logic                   all_released,
   output logic [2:0]             seq_state,
   output logic                   timeout_err,
   output logic [3:0]             retry_cnt
);
   localparam int MAX_AB = (MIN_ASSERT > LOCK_FILTER) ? MIN_ASSERT : LOCK_FILTER;
   localparam int MAX_CD = (RELEASE_GAP > READY_TIMEOUT) ? RELEASE_GAP : READY_TIMEOUT;
   localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAX_C) + 1;
   localparam int IW     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam logic [CW-1:0] HOLD_END = CW'(MIN_ASSERT - 1);
   localparam logic [CW-1:0] LOCK_END = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] GAP_END  = CW'(RELEASE_GAP - 1);
   localparam logic [CW-1:0] TMO_END  = CW'(READY_TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);

   typedef enum logic [2:0] {HOLD = 3'd0, LOCK = 3'd1, WAIT_RDY = 3'd2, GAP = 3'd3, RUN = 3'd4} state_t;

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt, cnt_nx;
   logic [IW-1:0]          idx, idx_nx;
   logic [NUM_DOMAINS-1:0] rst_nx;
   logic                   rel_nx, err_nx;
   logic [3:0]             retry_nx;
   logic                   lock_s, abort, rdy, tmo, restart;

   assign lock_s    = sync_q[SYNC_STAGES-1];
   // lock loss aborts every state except LOCK, where it only restarts the filter; HOLD handles both itself
   assign abort     = soft_rst_req | (~lock_s & (state != LOCK));
   assign rdy       = domain_ready[idx];
   assign tmo       = (state == WAIT_RDY) & ~abort & ~rdy & (cnt == TMO_END);
   assign restart   = ((state == HOLD) & soft_rst_req) | ((state == LOCK) & ~lock_s);
   assign seq_state = state;

   always_ff @(posedge pll_clk) begin
      if (sync_rst) begin
         sync_q       <= '0;
         state        <= HOLD;
         cnt          <= '0;
         idx          <= '0;
         rst_out      <= '1;
         rst_out_n    <= '0;
         all_released <= 1'b0;
         timeout_err  <= 1'b0;
         retry_cnt    <= 4'd0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], pll_lock};
         state        <= state_nx;
         cnt          <= cnt_nx;
         idx          <= idx_nx;
         rst_out      <= rst_nx;
         rst_out_n    <= ~rst_nx;
         all_released <= rel_nx;
         timeout_err  <= err_nx;
         retry_cnt    <= retry_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         HOLD:     state_nx = (!soft_rst_req && cnt == HOLD_END) ? LOCK : HOLD;
         LOCK:     state_nx = abort ? HOLD : (lock_s && cnt == LOCK_END) ? WAIT_RDY : LOCK;
         WAIT_RDY: state_nx = (abort || tmo) ? HOLD : rdy ? ((idx == LAST_IDX) ? RUN : GAP) : WAIT_RDY;
         GAP:      state_nx = abort ? HOLD : (cnt == GAP_END) ? WAIT_RDY : GAP;
         RUN:      state_nx = abort ? HOLD : RUN;
         default:  state_nx = HOLD;
      endcase
   end

   always_comb begin
      rst_nx   = rst_out;
      idx_nx   = idx;
      cnt_nx   = (state_nx != state || restart) ? '0 : cnt + 1'b1;
      rel_nx   = state_nx == RUN;
      err_nx   = timeout_err | tmo;
      retry_nx = (tmo && retry_cnt != 4'hf) ? retry_cnt + 4'd1 : retry_cnt;
      if (state_nx == HOLD) begin
         rst_nx = '1;
         idx_nx = '0;
      end else if (state == LOCK && state_nx == WAIT_RDY) begin
         rst_nx[0] = 1'b0;
         idx_nx    = '0;
      end else if (state == GAP && state_nx == WAIT_RDY) begin
         idx_nx         = idx + 1'b1;
         rst_nx[idx_nx] = 1'b0;
      end
   end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of reset_sequencer with small parameters
module tb_reset_sequencer;
   logic       pll_clk = 1'b0;
   logic       sync_rst, pll_lock, soft_rst_req;
   logic [1:0] domain_ready, rst_out, rst_out_n;
   logic       all_released, timeout_err;
   logic [2:0] seq_state;
   logic [3:0] retry_cnt;
   int         errors = 0;
   int         checks = 0;

   reset_sequencer #(
      .NUM_DOMAINS(2), .SYNC_STAGES(2), .MIN_ASSERT(4),
      .LOCK_FILTER(3), .RELEASE_GAP(2), .READY_TIMEOUT(5)
   ) dut (
      .pll_clk(pll_clk), .sync_rst(sync_rst), .pll_lock(pll_lock),
      .soft_rst_req(soft_rst_req), .domain_ready(domain_ready),
      .rst_out(rst_out), .rst_out_n(rst_out_n), .all_released(all_released),
      .seq_state(seq_state), .timeout_err(timeout_err), .retry_cnt(retry_cnt)
   );

   always #5 pll_clk = ~pll_clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge pll_clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_soft();
      soft_rst_req = 1'b1;
      tick(1);
      soft_rst_req = 1'b0;
   endtask

   initial begin
      sync_rst = 1'b1; pll_lock = 1'b1; soft_rst_req = 1'b0; domain_ready = 2'b11;
      tick(3);
      chk("rst_rst_out", rst_out, 2'b11);
      chk("rst_rst_out_n", rst_out_n, 2'b00);
      chk("rst_all_rel", all_released, 0);
      chk("rst_state", seq_state, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_retry", retry_cnt, 0);
      // clean sequence, cycle 0 starts here
      sync_rst = 1'b0;
      tick(3);  chk("c3_hold", seq_state, 0);
      tick(1);  chk("c4_lock", seq_state, 1);
      tick(2);  chk("c6_rst", rst_out, 2'b11);
      tick(1);  chk("c7_rst", rst_out, 2'b10);
      chk("c7_rst_n", rst_out_n, 2'b01);
      chk("c7_state", seq_state, 2);
      tick(1);  chk("c8_gap", seq_state, 3);
      tick(1);  chk("c9_rst", rst_out, 2'b10);
      tick(1);  chk("c10_rst", rst_out, 2'b00);
      chk("c10_all_rel", all_released, 0);
      tick(1);  chk("c11_all_rel", all_released, 1);
      chk("c11_state", seq_state, 4);
      chk("c11_rst_n", rst_out_n, 2'b11);
      domain_ready = 2'b00;
      tick(1);  chk("run_ignores_ready", seq_state, 4);
      // lock loss in RUN
      pll_lock = 1'b0;
      tick(3);
      chk("lockloss_rst", rst_out, 2'b11);
      chk("lockloss_all_rel", all_released, 0);
      chk("lockloss_state", seq_state, 0);
      pll_lock = 1'b1; domain_ready = 2'b11;
      tick(7);  chk("relock_c7_rst", rst_out, 2'b10);
      tick(4);  chk("relock_c11_all_rel", all_released, 1);
      // lock glitch during LOCK filter
      pulse_soft();
      chk("soft_run_rst", rst_out, 2'b11);
      chk("soft_run_state", seq_state, 0);
      chk("soft_run_all_rel", all_released, 0);
      tick(4);  chk("glitch_c4_lock", seq_state, 1);
      pll_lock = 1'b0;
      tick(1);  pll_lock = 1'b1;
      tick(2);  chk("glitch_c7_rst", rst_out, 2'b11);
      chk("glitch_c7_state", seq_state, 1);
      tick(3);  chk("glitch_c10_rst", rst_out, 2'b10);
      chk("glitch_c10_state", seq_state, 2);
      tick(1);  chk("glitch_c11_gap", seq_state, 3);
      // soft reset in GAP, then domain 1 never ready -> timeout
      pulse_soft();
      chk("soft_gap_rst", rst_out, 2'b11);
      chk("soft_gap_state", seq_state, 0);
      domain_ready = 2'b01;
      tick(8);  chk("idx0_gap", seq_state, 3);
      tick(2);  chk("tmo_c10_rst", rst_out, 2'b00);
      chk("tmo_c10_state", seq_state, 2);
      tick(4);  chk("tmo_c14_state", seq_state, 2);
      chk("tmo_c14_err", timeout_err, 0);
      tick(1);  chk("tmo_rst", rst_out, 2'b11);
      chk("tmo_state", seq_state, 0);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_retry", retry_cnt, 1);
      domain_ready = 2'b11;
      tick(11); chk("retry_run", seq_state, 4);
      chk("retry_all_rel", all_released, 1);
      chk("retry_err_sticky", timeout_err, 1);
      chk("retry_cnt_kept", retry_cnt, 1);
      // soft reset inside HOLD restarts the hold count
      pulse_soft();
      tick(2);  soft_rst_req = 1'b1;
      tick(1);  soft_rst_req = 1'b0;
      tick(6);  chk("holdrst_c9_rst", rst_out, 2'b11);
      chk("holdrst_c9_state", seq_state, 1);
      tick(1);  chk("holdrst_c10_rst", rst_out, 2'b10);
      tick(4);  chk("holdrst_c14_run", seq_state, 4);
      // repeated timeouts saturate retry_cnt
      domain_ready = 2'b00;
      pulse_soft();
      for (int i = 0; i < 13; i++) tick(12);
      chk("sat_14", retry_cnt, 14);
      tick(12); chk("sat_15", retry_cnt, 15);
      for (int i = 0; i < 3; i++) tick(12);
      chk("sat_hold", retry_cnt, 15);
      chk("sat_err", timeout_err, 1);
      // sync_rst mid WAIT_RDY
      tick(8);  chk("srst_wait_state", seq_state, 2);
      sync_rst = 1'b1;
      tick(1);
      chk("srst_rst_out", rst_out, 2'b11);
      chk("srst_rst_out_n", rst_out_n, 2'b00);
      chk("srst_state", seq_state, 0);
      chk("srst_err", timeout_err, 0);
      chk("srst_retry", retry_cnt, 0);
      chk("srst_all_rel", all_released, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
